set_match_gen: RTL and testbench

//  Stage directly upstream of the candidate accumulator. Loads a reference set of up to SET_N words.

---
 rtl/set_pkg.sv | 14 +
 rtl/set_cam_cmp.sv | 21 ++
 rtl/set_match_gen.sv | 132 +++++++++++++
 tb/tb_set_match_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// Shared defaults and FSM state encoding for the set-match stage and its
// comparator bank.
package set_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SET_N  = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CMP   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/set_cam_cmp.sv
// Parallel equality comparators against the reference set, gated by entry
// validity. Serves both load-time dedup and query matching.
module set_cam_cmp
    import set_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SET_N  = DEF_SET_N
) (
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] ref_data [SET_N],
    input  logic [SET_N-1:0]  ref_valid,
    output logic [SET_N-1:0]  match
);

    generate
        for (genvar gi = 0; gi < SET_N; gi++) begin : g_cmp
            assign match[gi] = ref_valid[gi] && (ref_data[gi] == key);
        end
    endgenerate

endmodule

// File: rtl/set_match_gen.sv
// Loads a deduplicated reference set, then streams queries against it and
// emits one registered hit bit per entry for the downstream accumulator.
module set_match_gen
    import set_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SET_N  = DEF_SET_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [SET_N-1:0]  hit,
    output logic              acc_en,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] ref_q [SET_N];
    logic [DATA_W-1:0] ref_d [SET_N];
    logic [SET_N-1:0]  ref_valid_q, ref_valid_d;
    logic              overflow_q, overflow_d;
    logic [SET_N-1:0]  hit_q, hit_d;
    logic              acc_en_q, acc_en_d;

    logic [SET_N-1:0]  match;
    logic [SET_N-1:0]  free_onehot;
    logic [SET_N-1:0]  ref_we;
    logic              set_full;
    logic              accept;

    set_cam_cmp #(
        .DATA_W (DATA_W),
        .SET_N  (SET_N)
    ) u_cam (
        .key       (in_data),
        .ref_data  (ref_q),
        .ref_valid (ref_valid_q),
        .match     (match)
    );

    assign in_ready = (state_q == ST_LOAD) || (state_q == ST_CMP);
    assign accept   = in_valid && in_ready;
    assign set_full = &ref_valid_q;
    // Adding one to the valid mask carries through the low run of ones,
    // isolating the lowest clear bit as a one-hot slot select.
    assign free_onehot = ~ref_valid_q & (ref_valid_q + SET_N'(1));

    always_comb begin
        state_d     = state_q;
        ref_valid_d = ref_valid_q;
        overflow_d  = overflow_q;
        hit_d       = '0;
        acc_en_d    = 1'b0;
        ref_we      = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    ref_valid_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (match == '0) begin
                        if (set_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            ref_we      = free_onehot;
                            ref_valid_d = ref_valid_q | free_onehot;
                        end
                    end
                    if (in_last) begin
                        state_d = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                if (accept) begin
                    hit_d    = match;
                    acc_en_d = 1'b1;
                    if (in_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < SET_N; gi++) begin : g_ref
            assign ref_d[gi] = ref_we[gi] ? in_data : ref_q[gi];

            // Reference words need no reset: they are only observed through ref_valid.
            always_ff @(posedge clk) begin
                ref_q[gi] <= ref_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ref_valid_q <= '0;
            overflow_q  <= 1'b0;
            hit_q       <= '0;
            acc_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_valid_q <= ref_valid_d;
            overflow_q  <= overflow_d;
            hit_q       <= hit_d;
            acc_en_q    <= acc_en_d;
        end
    end

    assign hit      = hit_q;
    assign acc_en   = acc_en_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_set_match_gen.sv
// Directed self-checking bench for set_match_gen: load/query jobs with
// hand-computed hit patterns, overflow, empty load, mid-job reset and gaps.
module tb_set_match_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [3:0] hit;
    logic       acc_en;
    logic       busy;
    logic       done;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] vec [8];
    int         vlen;

    always #5 clk = ~clk;

    set_match_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .hit      (hit),
        .acc_en   (acc_en),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_vec;
        for (int i = 0; i < vlen; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = (i == vlen - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({in_ready, busy, done, overflow, acc_en, hit} !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", {in_ready, busy, done, overflow, acc_en, hit}, 9'b0);
        end
        $display("reset: rdy=%b busy=%b done=%b ovf=%b acc=%b hit=%b", in_ready, busy, done, overflow, acc_en, hit);
    endtask

    task automatic test_basic;
        logic [7:0] q [4];
        logic [3:0] e [4];
        int cand;
        q = '{8'd7, 8'd1, 8'd12, 8'd12};
        e = '{4'b0010, 4'b0000, 4'b1000, 4'b1000};
        cand = 0;
        do_start();
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_after_start got busy=%b rdy=%b exp 1 1", busy, in_ready);
        end
        vec[0] = 8'd3; vec[1] = 8'd7; vec[2] = 8'd9; vec[3] = 8'd12; vlen = 4;
        load_vec();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = q[i]; in_last = (i == 3);
            tick();
            if (acc_en === 1'b1 && hit !== 4'b0000) cand++;
            total++;
            if (hit !== e[i] || acc_en !== 1'b1) begin
                bad++;
                $display("FAIL basic_query%0d got hit=%b acc=%b exp hit=%b acc=1", i, hit, acc_en, e[i]);
            end
            $display("basic: query=%0d hit=%b acc_en=%b", q[i], hit, acc_en);
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        total++;
        if (done !== 1'b1 || acc_en !== 1'b0 || hit !== 4'b0) begin
            bad++;
            $display("FAIL basic_done got done=%b acc=%b hit=%b exp done=1 acc=0 hit=0000", done, acc_en, hit);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got done=%b busy=%b exp 0 0", done, busy);
        end
        total++;
        if (cand !== 3) begin
            bad++;
            $display("FAIL basic_candidate got=%0d exp=3", cand);
        end
        $display("basic: candidate=%0d", cand);
    endtask

    task automatic test_dedup;
        do_start();
        vec[0] = 8'd5; vec[1] = 8'd5; vec[2] = 8'd6; vlen = 3;
        load_vec();
        total++;
        if (dut.ref_valid_q !== 4'b0011) begin
            bad++;
            $display("FAIL dedup_ref_valid got=%b exp=0011", dut.ref_valid_q);
        end
        in_valid = 1'b1; in_data = 8'd5; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if (hit !== 4'b0001 || acc_en !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL dedup_query got hit=%b acc=%b ovf=%b exp 0001 1 0", hit, acc_en, overflow);
        end
        $display("dedup: query=5 hit=%b acc_en=%b ovf=%b", hit, acc_en, overflow);
        tick(); tick();
    endtask

    task automatic test_overflow;
        logic [7:0] q [2];
        logic [3:0] e [2];
        q = '{8'd8, 8'd4};
        e = '{4'b0000, 4'b1000};
        do_start();
        vec[0] = 8'd1; vec[1] = 8'd2; vec[2] = 8'd3; vec[3] = 8'd4; vec[4] = 8'd8; vlen = 5;
        load_vec();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_flag got=%b exp=1", overflow);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = q[i]; in_last = (i == 1);
            tick();
            total++;
            if (hit !== e[i] || acc_en !== 1'b1) begin
                bad++;
                $display("FAIL overflow_query%0d got hit=%b acc=%b exp hit=%b acc=1", i, hit, acc_en, e[i]);
            end
            $display("overflow: query=%0d hit=%b acc_en=%b", q[i], hit, acc_en);
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick(); tick();
        total++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL overflow_sticky got ovf=%b busy=%b exp 1 0", overflow, busy);
        end
    endtask

    task automatic test_empty;
        do_start();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL empty_ovf_cleared got=%b exp=0", overflow);
        end
        vec[0] = 8'd0; vlen = 1;
        load_vec();
        total++;
        if (in_ready !== 1'b1 || dut.ref_valid_q !== 4'b0001) begin
            bad++;
            $display("FAIL empty_enter_cmp got rdy=%b refv=%b exp 1 0001", in_ready, dut.ref_valid_q);
        end
        // The single load word 0 becomes entry 0, so querying a value never loaded gives zero hits.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'd99; in_last = (i == 1);
            tick();
            total++;
            if (hit !== 4'b0000 || acc_en !== 1'b1) begin
                bad++;
                $display("FAIL empty_query%0d got hit=%b acc=%b exp 0000 1", i, hit, acc_en);
            end
            $display("empty: query=99 hit=%b acc_en=%b", hit, acc_en);
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL empty_done got=%b exp=1", done);
        end
        tick();
    endtask

    task automatic test_rst_mid;
        do_start();
        vec[0] = 8'd10; vec[1] = 8'd20; vlen = 2;
        load_vec();
        in_valid = 1'b1; in_data = 8'd10; in_last = 1'b0;
        tick();
        in_data = 8'd20;
        tick();
        total++;
        if (hit !== 4'b0010 || acc_en !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre got hit=%b acc=%b exp 0010 1", hit, acc_en);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || acc_en !== 1'b0 || hit !== 4'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_after got busy=%b acc=%b hit=%b rdy=%b exp 0 0 0000 0", busy, acc_en, hit, in_ready);
        end
        $display("rst_mid: busy=%b acc_en=%b hit=%b rdy=%b", busy, acc_en, hit, in_ready);
        do_start();
        vec[0] = 8'd1; vlen = 1;
        load_vec();
        in_valid = 1'b1; in_data = 8'd1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if (hit !== 4'b0001 || acc_en !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_restart got hit=%b acc=%b exp 0001 1", hit, acc_en);
        end
        tick(); tick();
    endtask

    task automatic test_gaps;
        do_start();
        vec[0] = 8'd4; vec[1] = 8'd5; vlen = 2;
        load_vec();
        in_valid = 1'b1; in_data = 8'd5; in_last = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (hit !== 4'b0010 || acc_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL gaps_q0 got hit=%b acc=%b busy=%b exp 0010 1 1", hit, acc_en, busy);
        end
        $display("gaps: query=5 hit=%b acc_en=%b", hit, acc_en);
        in_valid = 1'b0; in_data = 8'd4;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (hit !== 4'b0000 || acc_en !== 1'b0) begin
                bad++;
                $display("FAIL gaps_idle%0d got hit=%b acc=%b exp 0000 0", i, hit, acc_en);
            end
            $display("gaps: no accept hit=%b acc_en=%b", hit, acc_en);
        end
        in_valid = 1'b1; in_data = 8'd4; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if (hit !== 4'b0001 || acc_en !== 1'b1) begin
            bad++;
            $display("FAIL gaps_q1 got hit=%b acc=%b exp 0001 1", hit, acc_en);
        end
        $display("gaps: query=4 hit=%b acc_en=%b", hit, acc_en);
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL gaps_done got=%b exp=1", done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL gaps_start_in_done got busy=%b done=%b exp 0 0", busy, done);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL gaps_stay_idle got busy=%b exp 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dedup();
        test_overflow();
        test_empty();
        test_rst_mid();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
